// File: rtl/cpu_fetch_queue_pkg.sv
// Shared fetch-queue types: queue entry layout and fetch FSM states.
// Supplies defaults for VIRTUAL_ADDR_WIDTH / BOOT_ADDR when the build does not define them.
`ifndef VIRTUAL_ADDR_WIDTH
`define VIRTUAL_ADDR_WIDTH 32
`endif
`ifndef BOOT_ADDR
`define BOOT_ADDR 32'h0000_1000
`endif

package cpu_fetch_queue_pkg;
  localparam int FQ_ADDR_W = `VIRTUAL_ADDR_WIDTH;
  localparam int FQ_DATA_W = 32;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_queue_state_t;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_DATA_W-1:0] instr;
    logic                 fault;
  } fetch_queue_entry_t;
endpackage

// File: rtl/cpu_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; pointers carry one extra wrap bit.
module cpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic                         do_push, do_pop;

  assign count   = count_q;
  assign full    = (count_q == DEPTH[AW:0]);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Push qualifies on the start-of-cycle count, so a full queue never accepts even with a pop.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        wr_ptr_d = wr_ptr_q + ONE;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/cpu_fetch_queue.sv
// Fetch-to-decode stage: owns the fetch PC, queues hits and ITLB fault markers for decode.
// Optional perf counters (miss_cycles/full_cycles) when FETCH_QUEUE_PERF_EN is defined.
module cpu_fetch_queue
  import cpu_fetch_queue_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = `VIRTUAL_ADDR_WIDTH,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = `BOOT_ADDR
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  cache_hit,
  input  logic                  tlb_enable,
  input  logic                  tlb_hit,
  input  logic                  flush,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]           miss_cycles,
  output logic [31:0]           full_cycles,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_fault
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic                  fault;
  } entry_t;

  fetch_queue_state_t    state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  entry_t                push_entry, head;
  logic                  push, pop, full, empty, tlb_fault;
  logic [AW:0]           count;

  assign tlb_fault = tlb_enable && !tlb_hit;
  assign pop       = out_valid && out_ready;

  cpu_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= BOOT_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush)                                         state_d = FETCH;
    else if (state_q == FETCH && tlb_fault && !full)   state_d = FAULT;
  end

  // ITLB miss wins over a cache hit; the fault marker holds pc so the redirect owns recovery.
  always_comb begin
    push       = 1'b0;
    pc_d       = pc_q;
    push_entry = '{pc: pc_q, instr: instr, fault: 1'b0};
    if (flush) begin
      pc_d = next_pc;
    end else if (state_q == FETCH && !full) begin
      if (tlb_fault) begin
        push             = 1'b1;
        push_entry.instr = '0;
        push_entry.fault = 1'b1;
      end else if (cache_hit) begin
        push = 1'b1;
        pc_d = next_pc;
      end
    end
  end

  assign pc        = pc_q;
  assign out_valid = (count != '0);
  assign out_instr = empty ? '0 : head.instr;
  assign out_pc    = empty ? '0 : head.pc;
  assign out_fault = empty ? 1'b0 : head.fault;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] miss_cycles_q, miss_cycles_d, full_cycles_q, full_cycles_d;

  always_comb begin
    miss_cycles_d = miss_cycles_q;
    full_cycles_d = full_cycles_q;
    if (state_q == FETCH) begin
      if (!full && !tlb_fault && !cache_hit && miss_cycles_q != '1)
        miss_cycles_d = miss_cycles_q + 32'd1;
      if (full && full_cycles_q != '1)
        full_cycles_d = full_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      miss_cycles_q <= '0;
      full_cycles_q <= '0;
    end else begin
      miss_cycles_q <= miss_cycles_d;
      full_cycles_q <= full_cycles_d;
    end
  end

  assign miss_cycles = miss_cycles_q;
  assign full_cycles = full_cycles_q;
`endif
endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Bench for cpu_fetch_queue: directed scenarios with literal checks, then random traffic vs a queue model.
module tb_cpu_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc, next_pc, instr, out_instr, out_pc;
  logic        cache_hit, tlb_enable, tlb_hit, flush, out_valid, out_ready, out_fault;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] miss_cycles, full_cycles;
`endif

  cpu_fetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .next_pc    (next_pc),
    .instr      (instr),
    .cache_hit  (cache_hit),
    .tlb_enable (tlb_enable),
    .tlb_hit    (tlb_hit),
    .flush      (flush),
`ifdef FETCH_QUEUE_PERF_EN
    .miss_cycles(miss_cycles),
    .full_cycles(full_cycles),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_fault  (out_fault)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of entries, the fetch PC and a halted flag.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] pc_m;
  bit          halted_m;
  logic [31:0] miss_m, full_m;

  always @(posedge clock) begin : model
    bit was_full;
    if (reset) begin
      mq.delete();
      pc_m = BOOT;
      halted_m = 1'b0;
      miss_m = 0;
      full_m = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (!halted_m) begin
        if (was_full && full_m != 32'hFFFF_FFFF) full_m = full_m + 1;
        if (!was_full && !(tlb_enable && !tlb_hit) && !cache_hit && miss_m != 32'hFFFF_FFFF)
          miss_m = miss_m + 1;
      end
      if (flush) begin
        mq.delete();
        pc_m = next_pc;
        halted_m = 1'b0;
      end else begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (!halted_m && !was_full) begin
          if (tlb_enable && !tlb_hit) begin
            mq.push_back('{pc: pc_m, instr: 32'h0, fault: 1'b1});
            halted_m = 1'b1;
          end else if (cache_hit) begin
            mq.push_back('{pc: pc_m, instr: instr, fault: 1'b0});
            pc_m = next_pc;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc", pc, pc_m);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("out_pc", out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
      chk("out_instr", out_instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
      chk("out_fault", out_fault, (mq.size() != 0) ? mq[0].fault : 1'b0);
`ifdef FETCH_QUEUE_PERF_EN
      chk("miss_cycles", miss_cycles, miss_m);
      chk("full_cycles", full_cycles, full_m);
`endif
    end
  end

  // Advance one cycle; the fetch stage model proposes pc+4 unless a test overrides it.
  task automatic tick();
    @(posedge clock);
    #1;
    next_pc = pc_m + 32'd4;
    instr   = $urandom;
  endtask

  initial begin
    cache_hit = 1'b1; tlb_enable = 1'b0; tlb_hit = 1'b1; flush = 1'b0;
    out_ready = 1'b1; next_pc = BOOT + 32'd4; instr = 32'h0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset pc", pc, 32'h1000);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_pc", out_pc, 32'h0);

    // Streaming: one head per cycle, first valid one cycle after the first hit.
    tick(); chk("stream head0", out_pc, 32'h1000); chk("stream valid", out_valid, 1'b1);
    tick(); chk("stream head1", out_pc, 32'h1004);
    tick(); chk("stream head2", out_pc, 32'h1008);

    // Fill to full with decode stalled, then a single pop.
    flush = 1'b1; next_pc = 32'h1000; out_ready = 1'b0;
    tick(); flush = 1'b0;
    repeat (4) tick();
    chk("full head", out_pc, 32'h1000);
    chk("full pc", pc, 32'h1010);
    tick(); chk("full pc hold", pc, 32'h1010);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    chk("pop head", out_pc, 32'h1004);
    chk("pop no push pc", pc, 32'h1010);
    tick(); chk("push resumes pc", pc, 32'h1014);

    // Cache miss stalls pc.
    flush = 1'b1; next_pc = 32'h2000; out_ready = 1'b1;
    tick(); flush = 1'b0; cache_hit = 1'b0;
    repeat (3) tick();
    chk("miss pc hold", pc, 32'h2000);
    chk("miss no push", out_valid, 1'b0);
    cache_hit = 1'b1;
    tick(); chk("miss then hit", out_pc, 32'h2000);

    // ITLB fault marker and halt until flush.
    flush = 1'b1; next_pc = 32'h3000; out_ready = 1'b0;
    tick(); flush = 1'b0; tlb_enable = 1'b1; tlb_hit = 1'b0;
    tick();
    chk("fault flag", out_fault, 1'b1);
    chk("fault pc", out_pc, 32'h3000);
    chk("fault instr", out_instr, 32'h0);
    tlb_hit = 1'b1;
    tick(); tick();
    chk("fault halted pc", pc, 32'h3000);
    out_ready = 1'b1;
    tick(); chk("fault drained", out_valid, 1'b0);
    flush = 1'b1; next_pc = 32'h0800;
    tick(); flush = 1'b0;
    chk("redirect empty", out_valid, 1'b0);
    chk("redirect pc", pc, 32'h0800);
    tick(); chk("redirect fetch", out_pc, 32'h0800);

    // Flush with queued entries and same-cycle hit and pop.
    out_ready = 1'b0; tlb_enable = 1'b0;
    repeat (3) tick();
    flush = 1'b1; out_ready = 1'b1; next_pc = 32'h4000;
    tick(); flush = 1'b0; cache_hit = 1'b0;
    chk("flush empty", out_valid, 1'b0);
    chk("flush pc", pc, 32'h4000);
    tick(); chk("flush stays empty", out_valid, 1'b0);

    // Reset while halted with a full queue.
    cache_hit = 1'b1; flush = 1'b1; next_pc = 32'h5000; out_ready = 1'b0;
    tick(); flush = 1'b0;
    repeat (3) tick();
    tlb_enable = 1'b1; tlb_hit = 1'b0;
    tick(); chk("pre-reset valid", out_valid, 1'b1);
    reset = 1'b1;
    tick(); reset = 1'b0; tlb_enable = 1'b0;
    chk("mid reset pc", pc, 32'h1000);
    chk("mid reset valid", out_valid, 1'b0);
    chk("mid reset fault", out_fault, 1'b0);
    tick(); chk("post reset fetch", out_pc, 32'h1000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      #1;
      instr      = $urandom;
      cache_hit  = ($urandom_range(0, 3) != 0);
      tlb_enable = $urandom_range(0, 1);
      tlb_hit    = ($urandom_range(0, 5) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      next_pc    = flush ? ($urandom & 32'hFFFF_FFFC) : pc_m + 32'd4;
    end
    @(posedge clock);
    #1;
    reset = 1'b0; flush = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
